instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Encoder counterpart to the main control decoder: takes symbolic instruction fields and packs them into 32-bit RV32I words for R-type, addi, lw, sw and beq.
- Writes the encoded words sequentially into instruction memory through a one-cycle registered write port.
- Used by the bench/boot path to load programs into imem before the core leaves reset.
- Opcode classes match the core decoder's Op[6:4] keys: 011 R-type, 001 addi, 000 lw, 010 sw, 110 beq.

Parameters:
- ADDR_W, 8, word-address width of imem write port
- BASE_ADDR, 0, first word address written after reset/clear
- DEPTH, 256, max words loadable (must be <= 2**ADDR_W - BASE_ADDR)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clear_i  in  1  synchronous restart: pointer to BASE_ADDR, count 0, err cleared
- valid_i  in  1  instruction fields valid
- ready_o  out  1  encoder can accept this cycle
- kind_i  in  3  0 R, 1 ADDI, 2 LW, 3 SW, 4 BEQ; 5-7 illegal
- funct3_i  in  3  R-type funct3
- funct7b5_i  in  1  R-type funct7[5] (sub/sra)
- rd_i  in  5  destination reg
- rs1_i  in  5  source reg 1
- rs2_i  in  5  source reg 2
- imm_i  in  13  signed immediate; I/S use imm_i[11:0] (must sign-fit 12 bits); B uses all 13 bits, bit0 must be 0
- we_o  out  1  imem write enable
- addr_o  out  ADDR_W  imem word address
- wdata_o  out  32  encoded instruction
- count_o  out  ADDR_W+1  words written since reset/clear
- full_o  out  1  count (incl. pending) == DEPTH
- err_o  out  1  sticky: illegal kind or immediate out of range

Behaviour:
- Reset: ready_o=1, we_o=0, addr_o=0, wdata_o=0, count_o=0, full_o=0, err_o=0, write pointer=BASE_ADDR.
- Accept when valid_i && ready_o. ready_o = !full_o && !rst_i && !clear_i.
- Latency 1: a field set accepted at cycle N gives we_o=1, addr_o=ptr, wdata_o=encoded word at N+1. Back-to-back accepts give one write per cycle.
- we_o deasserts the cycle after a cycle with no legal accept. addr_o/wdata_o hold their last values when we_o=0.
- Encoding:
  - R: {funct7b5,0,00000? no: {1'b0,funct7b5,5'b0,rs2,rs1,funct3,rd,0110011}.
  - ADDI: {imm[11:0],rs1,000,rd,0010011}.
  - LW: {imm[11:0],rs1,010,rd,0000011}.
  - SW: {imm[11:5],rs2,rs1,010,imm[4:0],0100011}.
  - BEQ: {imm[12],imm[10:5],rs2,rs1,000,imm[4:1],imm[11],1100011}.
  - Unused fields are ignored.
- Range check:
  - I/S kinds: imm_i[12] must equal imm_i[11].
  - BEQ: imm_i[0] must be 0.
  - Violation or kind 5-7: accepted (handshake completes), no write, count unchanged, err_o=1 from N+1 until rst/clear.
- Pointer/count: increment on each legal accept. full_o asserts the cycle after the DEPTH-th legal accept. The last write still issues at that cycle. No wrap-around: while full, ready_o=0 and valid_i is ignored.
- clear_i: same-cycle valid_i is not accepted. A write already pending from the previous cycle still completes on its address. Next cycle: ptr=BASE_ADDR, count=0, err=0.
- rst_i mid-stream: a pending write is dropped (we_o=0 next cycle) and all state returns to reset values.
- FSM: LOAD (normal) -> FULL when count reaches DEPTH. FULL -> LOAD only via clear_i/rst_i.

Decomposition:
- Shared package (core_defs_pkg): opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ; funct3 constants F3_LW_SW=010, F3_BEQ=000; kind enum values.
- One combinational sub-module, instr_field_packer: kind + fields -> {word, legal}. The top holds the handshake, pointer, count, FSM and output register.

Test Plan:
- R: kind=0, rd=3, rs1=1, rs2=2, f3=0, f7b5=0 (add x3,x1,x2) -> next cycle we_o=1, addr_o=0, wdata_o=0x002081B3, count_o=1.
- Back-to-back: addi x1,x0,5, then lw x2,8(x1), then sw x2,12(x1) -> writes 0x00500093 @0, 0x0080A103 @1, 0x0020A623 @2 on consecutive cycles.
- BEQ x1,x2,imm=-8 -> 0xFE208CE3. Same with imm=-7 -> no write, err_o=1, count unchanged.
- DEPTH=4: 5 legal accepts offered -> 4 writes (addr 0-3), full_o=1 and ready_o=0 after the 4th, 5th held off. clear_i -> ready_o=1, next write at addr 0.
- Illegal kind=6 -> no write, err_o=1. rst_i asserted while a write is pending -> we_o=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/core_defs_pkg.sv
// Shared RV32I encoding constants, instruction kinds and field bundle
// used by the program-loader encoder.
package core_defs_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_LW_SW = 3'b010;
  localparam logic [2:0] F3_BEQ   = 3'b000;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_ADDI = 3'd1,
    KIND_LW   = 3'd2,
    KIND_SW   = 3'd3,
    KIND_BEQ  = 3'd4
  } kind_e;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  typedef struct packed {
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } instr_fields_t;

  // A 13-bit immediate fits a signed 12-bit field when its top two bits agree.
  function automatic logic imm_fits12(input logic [12:0] imm);
    return imm[12] == imm[11];
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: instruction kind + symbolic fields -> RV32I word
// and a legality flag (known kind, immediate in range).
module instr_field_packer
  import core_defs_pkg::*;
(
  input  logic [2:0]         i_kind,
  input  instr_fields_t      i_fields,
  output logic [INSTR_W-1:0] o_word_c,
  output logic               o_legal_c
);

  logic [12:0] w_imm;
  assign w_imm = i_fields.imm;

  always_comb begin
    o_word_c  = '0;
    o_legal_c = 1'b0;
    case (i_kind)
      KIND_R: begin
        o_word_c  = {1'b0, i_fields.funct7b5, 5'b0, i_fields.rs2, i_fields.rs1,
                     i_fields.funct3, i_fields.rd, OP_RTYPE};
        o_legal_c = 1'b1;
      end
      KIND_ADDI: begin
        o_word_c  = {w_imm[11:0], i_fields.rs1, F3_ADDI, i_fields.rd, OP_ADDI};
        o_legal_c = imm_fits12(w_imm);
      end
      KIND_LW: begin
        o_word_c  = {w_imm[11:0], i_fields.rs1, F3_LW_SW, i_fields.rd, OP_LW};
        o_legal_c = imm_fits12(w_imm);
      end
      KIND_SW: begin
        o_word_c  = {w_imm[11:5], i_fields.rs2, i_fields.rs1, F3_LW_SW,
                     w_imm[4:0], OP_SW};
        o_legal_c = imm_fits12(w_imm);
      end
      KIND_BEQ: begin
        // Branch offsets are halfword aligned, so bit 0 is never encoded.
        o_word_c  = {w_imm[12], w_imm[10:5], i_fields.rs2, i_fields.rs1, F3_BEQ,
                     w_imm[4:1], w_imm[11], OP_BEQ};
        o_legal_c = ~w_imm[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instructions and streams them into imem through a
// one-cycle registered write port, filling sequential word addresses.
module instr_encoder_loader
  import core_defs_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [2:0]           kind_i,
  input  logic [2:0]           funct3_i,
  input  logic                 funct7b5_i,
  input  logic [4:0]           rd_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [12:0]          imm_i,
  output logic                 we_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [INSTR_W-1:0]   wdata_o,
  output logic [ADDR_W:0]      count_o,
  output logic                 full_o,
  output logic                 err_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e               r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]     r_count, w_count_nxt;
  logic                 r_err, w_err_nxt;
  logic                 r_we, w_we_nxt;
  logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
  logic [INSTR_W-1:0]   r_wdata, w_wdata_nxt;

  instr_fields_t        w_fields;
  logic [INSTR_W-1:0]   w_word;
  logic                 w_legal;
  logic                 w_accept;

  assign w_fields = '{funct3: funct3_i, funct7b5: funct7b5_i, rd: rd_i,
                      rs1: rs1_i, rs2: rs2_i, imm: imm_i};

  instr_field_packer u_packer (
    .i_kind    (kind_i),
    .i_fields  (w_fields),
    .o_word_c  (w_word),
    .o_legal_c (w_legal)
  );

  assign ready_o  = (r_state == ST_LOAD) && !rst_i && !clear_i;
  assign w_accept = valid_i && ready_o;

  // Next-state and next-output logic; illegal accepts only raise the sticky error.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    if (clear_i) begin
      w_state_nxt = ST_LOAD;
      w_ptr_nxt   = ADDR_W'(BASE_ADDR);
      w_count_nxt = '0;
      w_err_nxt   = 1'b0;
    end else if (w_accept) begin
      if (w_legal) begin
        w_we_nxt    = 1'b1;
        w_addr_nxt  = r_ptr;
        w_wdata_nxt = w_word;
        w_ptr_nxt   = r_ptr + ADDR_W'(1);
        w_count_nxt = r_count + CNT_W'(1);
        if (w_count_nxt == CNT_W'(DEPTH)) begin
          w_state_nxt = ST_FULL;
        end
      end else begin
        w_err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_LOAD;
      r_ptr   <= ADDR_W'(BASE_ADDR);
      r_count <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  assign we_o    = r_we;
  assign addr_o  = r_addr;
  assign wdata_o = r_wdata;
  assign count_o = r_count;
  assign full_o  = (r_state == ST_FULL);
  assign err_o   = r_err;

endmodule
